evm_input_conditioner: RTL and testbench
========================================

Name: evm_input_conditioner

Overview:
- Front-end stage directly upstream of the EVM voting FSM.
- Takes raw, asynchronous push buttons and slide switches from the board. Synchronises and debounces every input.
- Converts the three vote buttons into one-cycle, one-hot vote pulses, accepting exactly one vote per voter session.
- Rejects simultaneous presses. The FSM downstream sees clean, single-event inputs only.

Parameters:
- CNT_WIDTH, 20, width of each debounce counter.
- DEBOUNCE_CYCLES, 1000000, cycles an input must hold a new level before it is accepted (10 ms at 100 MHz). Must be >= 2 and < 2^CNT_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- btn_vote_raw  input  3  raw vote buttons; bit0 = candidate 1, bit1 = candidate 2, bit2 = candidate 3.
- sw_on_raw  input  1  raw EVM power switch.
- sw_ready_raw  input  1  raw candidate-ready switch.
- sw_done_raw  input  1  raw voting-session-done switch.
- sw_winner_raw  input  1  raw display-winner switch.
- sw_results_raw  input  2  raw display-results switches.
- vote_candidate_1  output  1  one-cycle vote pulse for candidate 1.
- vote_candidate_2  output  1  one-cycle vote pulse for candidate 2.
- vote_candidate_3  output  1  one-cycle vote pulse for candidate 3.
- switch_on_evm  output  1  debounced level.
- candidate_ready  output  1  debounced level.
- voting_session_done  output  1  debounced level.
- display_winner  output  1  debounced level.
- display_results  output  2  debounced levels, each bit debounced independently.
- ballot_armed  output  1  LED: a vote will be accepted now.
- multi_press_err  output  1  one-cycle pulse when a press is rejected because two or more buttons are held.

Behaviour:
- Reset: all outputs 0; all synchronisers, stable registers and counters 0; arbitration FSM enters LOCKED.
- Per-input conditioning, applied to 9 bits:
  - 2-FF synchroniser feeds a stable register plus a counter.
  - If sync == stable: counter is 0.
  - Else: counter increments. When counter == DEBOUNCE_CYCLES-1, stable <= sync and counter <= 0.
  - Any glitch back to the stable level before the count completes clears the counter.
- Latency: a clean edge on a raw input appears on the debounced level 2 + DEBOUNCE_CYCLES cycles later.
- Button events: press = rising edge of a debounced button (stable now 1, previous cycle 0). Release = debounced level 0.
- Arbitration FSM states:
  - LOCKED: waiting for a new voter.
    - -> ARMED on a rising edge of debounced candidate_ready while switch_on_evm = 1 and all buttons are released.
    - A ready edge that arrives while any button is held is ignored. It is not queued.
  - ARMED: ballot_armed = 1.
    - On any press with exactly one debounced button high: emit the matching vote pulse for one cycle, -> VOTED.
    - On any press with two or more buttons high (this includes same-cycle edges): multi_press_err pulse, no vote pulse, -> MULTI.
  - VOTED: waits for all buttons released -> LOCKED.
  - MULTI: waits for all buttons released -> ARMED (the voter retries). Further presses in MULTI are ignored.
- Power gating: whenever debounced switch_on_evm = 0, the FSM is forced to LOCKED next cycle, and vote pulses and multi_press_err are suppressed in that same cycle.
- Vote pulse properties:
  - At most one of the three is high in any cycle.
  - Each is exactly 1 cycle wide.
  - Registered output: asserted the cycle after the press edge is detected.
- Level outputs are the stable registers, driven directly. No additional latency beyond the latency stated above.
- Reset mid-debounce or mid-session: everything clears immediately. After reset release, the first vote requires a fresh candidate_ready rise.

Decomposition:
- Shared package evm_pkg holds:
  - Arbitration state encoding: LOCKED, ARMED, VOTED, MULTI (2-bit).
  - Default DEBOUNCE_CYCLES and CNT_WIDTH constants.
  - Candidate index constants 1..3.
- Sub-module evm_debounce: one-bit synchroniser plus debounce counter, parameterised by CNT_WIDTH and DEBOUNCE_CYCLES. Instantiated 9 times.
- The arbitration FSM lives in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
- Bounce rejection: sw_on_raw toggles 1/0/1 at 2-cycle intervals, then holds 1 -> switch_on_evm rises exactly 6 cycles after the final edge; it never pulses earlier.
- Single vote: on=1, ready rises, then btn_vote_raw = 3'b010 held 20 cycles -> exactly one vote_candidate_2 pulse 1 cycle wide; ballot_armed goes 1 then 0.
- Double-vote block: after a vote, release the button and press btn 3'b001 again without toggling ready -> no pulse. Toggle ready 0->1, press again -> one vote_candidate_1 pulse.
- Simultaneous press: ARMED, btn_vote_raw = 3'b101 in the same cycle -> multi_press_err pulse, no vote pulse. Release all, press 3'b100 -> vote_candidate_3 pulse.
- Power-off mid-session: ARMED, drop sw_on_raw, then press 3'b001 after switch_on_evm falls -> no pulse; ballot_armed = 0; FSM is in LOCKED.
- Async reset: assert rst low mid-count -> all outputs 0 in the same cycle. After release, a press without a ready rise -> no pulse.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared definitions for the EVM input conditioning front end: arbitration
// state encoding, default debounce sizing and candidate indices.
package evm_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ARMED  = 2'd1,
    VOTED  = 2'd2,
    MULTI  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_CNT_WIDTH       = 20;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  localparam int CAND_1         = 1;
  localparam int CAND_2         = 2;
  localparam int CAND_3         = 3;
  localparam int NUM_CANDIDATES = 3;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/evm_debounce.sv
// One-bit 2-FF synchroniser followed by a hold-time debouncer. The level
// moves to the synchronised value only after it has held for DEBOUNCE_CYCLES.
module evm_debounce
  import evm_pkg::*;
#(
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 meta;
  logic                 sync;
  logic                 stable;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      // A return to the stable level at any point restarts the hold window.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/evm_input_conditioner.sv
// Conditions raw EVM buttons/switches into clean levels and arbitrates the
// vote buttons into single one-hot vote pulses, one per armed voter session.
module evm_input_conditioner
  import evm_pkg::*;
#(
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_vote_raw,
  input  logic       sw_on_raw,
  input  logic       sw_ready_raw,
  input  logic       sw_done_raw,
  input  logic       sw_winner_raw,
  input  logic [1:0] sw_results_raw,
  output logic       vote_candidate_1,
  output logic       vote_candidate_2,
  output logic       vote_candidate_3,
  output logic       switch_on_evm,
  output logic       candidate_ready,
  output logic       voting_session_done,
  output logic       display_winner,
  output logic [1:0] display_results,
  output logic       ballot_armed,
  output logic       multi_press_err,
  output logic [1:0] arb_state
);

  localparam int NUM_INPUTS = 9;

  logic [NUM_INPUTS-1:0] raw_vec;
  logic [NUM_INPUTS-1:0] deb_vec;

  assign raw_vec = {sw_results_raw, sw_winner_raw, sw_done_raw,
                    sw_ready_raw, sw_on_raw, btn_vote_raw};

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_deb
    evm_debounce #(
      .CNT_WIDTH       (CNT_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_vec[g]),
      .level (deb_vec[g])
    );
  end

  logic [2:0] btn_deb;
  assign btn_deb             = deb_vec[2:0];
  assign switch_on_evm       = deb_vec[3];
  assign candidate_ready     = deb_vec[4];
  assign voting_session_done = deb_vec[5];
  assign display_winner      = deb_vec[6];
  assign display_results     = deb_vec[8:7];

  logic [2:0] btn_prev;
  logic       ready_prev;
  logic [2:0] btn_press;
  logic       any_press;
  logic       all_released;
  logic       ready_rise;

  assign btn_press    = btn_deb & ~btn_prev;
  assign any_press    = |btn_press;
  assign all_released = (btn_deb == 3'b000);
  assign ready_rise   = candidate_ready & ~ready_prev;

  arb_state_t state_q, state_d;
  logic [2:0] vote_q, vote_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOCKED;
      vote_q     <= 3'b000;
      err_q      <= 1'b0;
      btn_prev   <= 3'b000;
      ready_prev <= 1'b0;
    end else begin
      state_q    <= state_d;
      vote_q     <= vote_d;
      err_q      <= err_d;
      btn_prev   <= btn_deb;
      ready_prev <= candidate_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    vote_d  = 3'b000;
    err_d   = 1'b0;
    if (!switch_on_evm) begin
      state_d = LOCKED;
    end else begin
      case (state_q)
        LOCKED: if (ready_rise && all_released) state_d = ARMED;
        ARMED: begin
          if (any_press) begin
            // Any press that leaves more than one button down is a rejected ballot.
            if (is_onehot3(btn_deb)) begin
              vote_d  = btn_deb;
              state_d = VOTED;
            end else begin
              err_d   = 1'b1;
              state_d = MULTI;
            end
          end
        end
        VOTED:   if (all_released) state_d = LOCKED;
        MULTI:   if (all_released) state_d = ARMED;
        default: state_d = LOCKED;
      endcase
    end
  end

  assign vote_candidate_1 = vote_q[CAND_1-1];
  assign vote_candidate_2 = vote_q[CAND_2-1];
  assign vote_candidate_3 = vote_q[CAND_3-1];
  assign multi_press_err  = err_q;
  assign ballot_armed     = (state_q == ARMED) && switch_on_evm;
  assign arb_state        = state_q;

endmodule

// File: tb/tb_evm_input_conditioner.sv
// Directed bench for evm_input_conditioner with a short debounce window.
module tb_evm_input_conditioner;
  import evm_pkg::*;

  localparam int CW = 4;
  localparam int DC = 4;

  logic       clk;
  logic       rst;
  logic [2:0] btn_vote_raw;
  logic       sw_on_raw, sw_ready_raw, sw_done_raw, sw_winner_raw;
  logic [1:0] sw_results_raw;
  logic       vote_candidate_1, vote_candidate_2, vote_candidate_3;
  logic       switch_on_evm, candidate_ready, voting_session_done, display_winner;
  logic [1:0] display_results;
  logic       ballot_armed, multi_press_err;
  logic [1:0] arb_state;

  evm_input_conditioner #(.CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .btn_vote_raw        (btn_vote_raw),
    .sw_on_raw           (sw_on_raw),
    .sw_ready_raw        (sw_ready_raw),
    .sw_done_raw         (sw_done_raw),
    .sw_winner_raw       (sw_winner_raw),
    .sw_results_raw      (sw_results_raw),
    .vote_candidate_1    (vote_candidate_1),
    .vote_candidate_2    (vote_candidate_2),
    .vote_candidate_3    (vote_candidate_3),
    .switch_on_evm       (switch_on_evm),
    .candidate_ready     (candidate_ready),
    .voting_session_done (voting_session_done),
    .display_winner      (display_winner),
    .display_results     (display_results),
    .ballot_armed        (ballot_armed),
    .multi_press_err     (multi_press_err),
    .arb_state           (arb_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int c1, c2, c3, ce, multi_hot;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    c1 = 0; c2 = 0; c3 = 0; ce = 0;
  endtask

  // Advance n cycles, tallying high cycles of every pulse output.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (vote_candidate_1) c1++;
      if (vote_candidate_2) c2++;
      if (vote_candidate_3) c3++;
      if (multi_press_err) ce++;
      if ((int'(vote_candidate_1) + int'(vote_candidate_2) + int'(vote_candidate_3)) > 1)
        multi_hot++;
    end
  endtask

  task automatic arm_ballot(input string tag);
    sw_ready_raw = 1'b0;
    watch(10);
    sw_ready_raw = 1'b1;
    watch(10);
    check_eq({tag, "_armed"}, 32'(ballot_armed), 32'd1);
    check_eq({tag, "_state_armed"}, 32'(arb_state), 32'(ARMED));
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({vote_candidate_1, vote_candidate_2, vote_candidate_3, switch_on_evm,
                candidate_ready, voting_session_done, display_winner, display_results,
                ballot_armed, multi_press_err, arb_state});
  endfunction

  initial begin
    multi_hot      = 0;
    rst            = 1'b0;
    btn_vote_raw   = 3'b000;
    sw_on_raw      = 1'b0;
    sw_ready_raw   = 1'b0;
    sw_done_raw    = 1'b0;
    sw_winner_raw  = 1'b0;
    sw_results_raw = 2'b00;
    clear_counts();
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b1;

    // Bounce rejection on the power switch
    sw_on_raw = 1'b1;
    for (int i = 0; i < 2; i++) begin @(negedge clk); check_eq("bounce_early_a", 32'(switch_on_evm), 32'd0); end
    sw_on_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); check_eq("bounce_early_b", 32'(switch_on_evm), 32'd0); end
    sw_on_raw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("bounce_cyc%0d", i), 32'(switch_on_evm), (i == 6) ? 32'd1 : 32'd0);
    end

    // Independent debounce of the results switches
    sw_results_raw = 2'b10;
    watch(8);
    check_eq("results_level", 32'(display_results), 32'h2);
    check_eq("results_state", 32'(arb_state), 32'(LOCKED));

    // Single vote
    arm_ballot("single");
    clear_counts();
    btn_vote_raw = 3'b010;
    watch(20);
    check_eq("single_c2", 32'(c2), 32'd1);
    check_eq("single_c1c3", 32'(c1 + c3), 32'd0);
    check_eq("single_err", 32'(ce), 32'd0);
    check_eq("single_disarmed", 32'(ballot_armed), 32'd0);
    check_eq("single_state_voted", 32'(arb_state), 32'(VOTED));
    btn_vote_raw = 3'b000;
    watch(10);
    check_eq("single_state_locked", 32'(arb_state), 32'(LOCKED));

    // Double-vote block, then a fresh ready rise
    clear_counts();
    btn_vote_raw = 3'b001;
    watch(12);
    check_eq("double_blocked", 32'(c1 + c2 + c3), 32'd0);
    btn_vote_raw = 3'b000;
    watch(10);
    arm_ballot("double");
    clear_counts();
    btn_vote_raw = 3'b001;
    watch(12);
    check_eq("double_c1", 32'(c1), 32'd1);
    check_eq("double_others", 32'(c2 + c3), 32'd0);
    btn_vote_raw = 3'b000;
    watch(10);

    // Simultaneous press
    arm_ballot("multi");
    clear_counts();
    btn_vote_raw = 3'b101;
    watch(12);
    check_eq("multi_err", 32'(ce), 32'd1);
    check_eq("multi_no_vote", 32'(c1 + c2 + c3), 32'd0);
    check_eq("multi_state", 32'(arb_state), 32'(MULTI));
    btn_vote_raw = 3'b000;
    watch(10);
    check_eq("multi_rearmed", 32'(arb_state), 32'(ARMED));
    clear_counts();
    btn_vote_raw = 3'b100;
    watch(12);
    check_eq("multi_c3", 32'(c3), 32'd1);
    check_eq("multi_c3_others", 32'(c1 + c2 + ce), 32'd0);
    btn_vote_raw = 3'b000;
    watch(10);

    // Power-off mid-session
    arm_ballot("poweroff");
    sw_on_raw = 1'b0;
    watch(10);
    check_eq("poweroff_level", 32'(switch_on_evm), 32'd0);
    clear_counts();
    btn_vote_raw = 3'b001;
    watch(12);
    check_eq("poweroff_no_vote", 32'(c1 + c2 + c3 + ce), 32'd0);
    check_eq("poweroff_disarmed", 32'(ballot_armed), 32'd0);
    check_eq("poweroff_state", 32'(arb_state), 32'(LOCKED));
    btn_vote_raw = 3'b000;
    sw_on_raw = 1'b1;
    watch(10);

    // Asynchronous reset mid-count
    arm_ballot("reset");
    sw_ready_raw = 1'b0;
    watch(3);
    #2 rst = 1'b0;
    #1 check_eq("reset_async_outputs", all_outputs(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    watch(10);
    check_eq("reset_on_again", 32'(switch_on_evm), 32'd1);
    clear_counts();
    btn_vote_raw = 3'b010;
    watch(12);
    check_eq("reset_no_vote", 32'(c1 + c2 + c3 + ce), 32'd0);
    check_eq("reset_state_locked", 32'(arb_state), 32'(LOCKED));
    btn_vote_raw = 3'b000;
    watch(4);

    check_eq("vote_onehot", 32'(multi_hot), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
